i2c_txn_scheduler: RTL and testbench
====================================

Name: i2c_txn_scheduler

Overview:
- Shares one byte-level I2C master engine between NUM_REQ requesters. Each requester submits a register-level transaction: a write of 1 byte, or a random read of 1 byte.
- The block arbitrates round-robin and expands the winner's transaction into the engine's primitive sequence: START+addr, WRITE, repeated START, READ, STOP.
- It returns read data and NACK status to the winning requester. It replaces hardcoded command tables in front of the engine.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 4096, per-primitive watchdog limit in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester transaction request
- req_ready_o  out  NUM_REQ  one-hot accept pulse
- req_rw_i  in  NUM_REQ  1=read, 0=write
- req_dev_i  in  7*NUM_REQ  7-bit device address, requester k at [7k+6:7k]
- req_reg_i  in  8*NUM_REQ  register address
- req_wdata_i  in  8*NUM_REQ  write data
- rsp_valid_o  out  NUM_REQ  one-hot, 1-cycle completion pulse
- rsp_rdata_o  out  8  read data, valid with rsp_valid_o
- rsp_nack_o  out  1  1 = transaction aborted (NACK or timeout)
- cmd_valid_o  out  1  primitive request to engine
- cmd_ready_i  in  1  engine accepts primitive
- cmd_op_o  out  2  0=START(+addr byte), 1=WRITE, 2=READ, 3=STOP
- cmd_data_o  out  8  byte for START/WRITE
- cmd_nack_o  out  1  master NACKs after READ (always 1 for READ here)
- done_i  in  1  engine finished current primitive (1-cycle pulse)
- done_ack_n_i  in  1  slave NACKed the byte (valid with done_i)
- done_rdata_i  in  8  received byte (valid with done_i on READ)

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; round-robin pointer=0; timeout counter=0.
- Reset asserted mid-transaction aborts immediately. No STOP is issued, no response is given, and the engine is expected to be reset from the same rst_i.
- FSM states: IDLE, GRANT, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Pulse req_ready_o[k] for 1 cycle and latch rw/dev/reg/wdata into a local register.
  - Move to GRANT. Pointer becomes k+1 mod NUM_REQ.
- GRANT: load the step index with 0, then go to ISSUE.
- Step sequences:
  - Write: START{dev,0}, WRITE reg, WRITE wdata, STOP.
  - Read: START{dev,0}, WRITE reg, START{dev,1}, READ, STOP.
- ISSUE:
  - Drive cmd_valid_o=1 with op/data/cmd_nack_o for the current step.
  - Hold op/data stable until cmd_valid_o && cmd_ready_i, then drop cmd_valid_o and go to WAIT.
- WAIT, on done_i:
  - READ step: latch done_rdata_i.
  - START/WRITE step with done_ack_n_i=1: set the abort flag and jump the step index to STOP.
  - Otherwise advance the step index.
  - After the STOP step completes, go to RESP; otherwise go to ISSUE.
- RESP:
  - Pulse rsp_valid_o[k] with rsp_nack_o = abort flag.
  - rsp_rdata_o = latched byte for a read, 0 for a write or an abort.
  - Clear the abort flag and return to IDLE.
- done_i outside WAIT is ignored. done_ack_n_i on STOP/READ is ignored.
- Minimum latency per primitive: 2 cycles, ISSUE plus handshake.
- Back-to-back transactions have 1 IDLE cycle between STOP completion and the next grant.
- Requester inputs must be held until req_ready_o. Later changes do not affect the latched transaction.

Optional Feature:
- Macro: I2C_TXN_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on each entry to ISSUE or WAIT and increments each cycle in those states.
  - At TIMEOUT_CYCLES-1 it sets the abort flag.
  - If the pending step is not STOP, it forces the STOP step.
  - If STOP itself times out, it goes directly to RESP with rsp_nack_o=1.
- Undefined: no counter; ISSUE and WAIT wait indefinitely.

Decomposition:
- Shared package i2c_pkg: cmd_op encodings (OP_START/OP_WRITE/OP_READ/OP_STOP), scheduler FSM state encodings, step-index constants.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin, inputs req vector + advance strobe, output one-hot grant + index. Reusable by other shared-bus controllers.

Test Plan:
- Single write:
  - Stimulus: req0 rw=0, dev=0x66, reg=0x01, wdata=0xA5; engine always ready, always ACK.
  - Response: cmd sequence START 0xCC, WRITE 0x01, WRITE 0xA5, STOP; rsp_valid_o=01, rsp_nack_o=0.
- Single read:
  - Stimulus: req1 rw=1, dev=0x1A, reg=0x01; engine returns 0x5C.
  - Response: START 0x34, WRITE 0x01, START 0x35, READ (cmd_nack_o=1), STOP; rsp_valid_o=10, rsp_rdata_o=0x5C.
- Address NACK:
  - Stimulus: done_ack_n_i=1 on the first START.
  - Response: next cmd is STOP; rsp_nack_o=1, rsp_rdata_o=0.
- Fairness:
  - Stimulus: req0 and req1 held valid continuously.
  - Response: grants alternate 0,1,0,1 over 4 transactions; cmd_valid_o never overlaps a pending WAIT.
- Backpressure:
  - Stimulus: cmd_ready_i low for 10 cycles during ISSUE.
  - Response: cmd_op_o/cmd_data_o stable throughout; one accept only.
- Reset mid-WAIT:
  - Stimulus: rst_i pulse during a READ step.
  - Response: all outputs 0 asynchronously; no rsp_valid_o; next request is granted from pointer 0.
  - With I2C_TXN_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, withholding done_i instead gives STOP issued after 16 cycles and rsp_nack_o=1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C transaction scheduler: engine opcodes, FSM states,
// step indices and the latched transaction record.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_RESP
  } sched_state_e;

  typedef logic [2:0] step_t;
  // STEP_SEC is WRITE wdata for a write, repeated START for a read.
  localparam step_t STEP_START = 3'd0;
  localparam step_t STEP_REG   = 3'd1;
  localparam step_t STEP_SEC   = 3'd2;
  localparam step_t STEP_READ  = 3'd3;
  localparam step_t STEP_STOP  = 3'd4;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] regad;
    logic [7:0] wdata;
  } txn_t;

  function automatic step_t next_step(step_t s, logic rw);
    return (s == STEP_SEC && !rw) ? STEP_STOP : s + 3'd1;
  endfunction

endpackage

// File: rtl/i2c_txn_scheduler_if.sv
// Requester and byte-engine signals of the I2C transaction scheduler.
// master = scheduler side, slave = requesters/engine side.
interface i2c_txn_scheduler_if #(parameter int NUM_REQ = 2) ();
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   req_rw_i;
  logic [7*NUM_REQ-1:0] req_dev_i;
  logic [8*NUM_REQ-1:0] req_reg_i;
  logic [8*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]   rsp_valid_o;
  logic [7:0]           rsp_rdata_o;
  logic                 rsp_nack_o;
  logic                 cmd_valid_o;
  logic                 cmd_ready_i;
  logic [1:0]           cmd_op_o;
  logic [7:0]           cmd_data_o;
  logic                 cmd_nack_o;
  logic                 done_i;
  logic                 done_ack_n_i;
  logic [7:0]           done_rdata_i;

  modport master (
    input  req_valid_i, req_rw_i, req_dev_i, req_reg_i, req_wdata_i,
           cmd_ready_i, done_i, done_ack_n_i, done_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_nack_o,
           cmd_valid_o, cmd_op_o, cmd_data_o, cmd_nack_o
  );

  modport slave (
    output req_valid_i, req_rw_i, req_dev_i, req_reg_i, req_wdata_i,
           cmd_ready_i, done_i, done_ack_n_i, done_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_nack_o,
           cmd_valid_o, cmd_op_o, cmd_data_o, cmd_nack_o
  );
endinterface

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer;
// adv_i commits the grant and moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  localparam int SW = IW + 1;

  logic [IW-1:0] ptr_q;
  logic [SW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + SW'(i);
      if (cand >= SW'(N)) cand = cand - SW'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IW-1:0]]   = 1'b1;
        idx_o                 = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      ptr_q <= '0;
    else if (adv_i) ptr_q <= (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
  end
endmodule

// File: rtl/i2c_txn_scheduler.sv
// Round-robin front end that expands register-level I2C transactions into byte-engine
// primitives. Optional per-primitive watchdog: define I2C_TXN_SCHED_TIMEOUT_EN.
module i2c_txn_scheduler
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic            clk_i,
  input logic            rst_i,
  i2c_txn_scheduler_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e       state_q, state_d;
  step_t              step_q, step_d;
  txn_t               txn_q, txn_sel;
  logic [IW-1:0]      owner_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [7:0]         rdata_q, rdata_d;
  logic               abort_q, abort_d, adv, tmo_hit;
  cmd_op_e            op;
  logic [7:0]         op_data;
  logic               op_nack;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.req_valid_i),
    .adv_i (adv),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    txn_sel.rw    = bus.req_rw_i[gnt_idx];
    txn_sel.dev   = bus.req_dev_i[7*gnt_idx +: 7];
    txn_sel.regad = bus.req_reg_i[8*gnt_idx +: 8];
    txn_sel.wdata = bus.req_wdata_i[8*gnt_idx +: 8];
  end

  always_comb begin
    op      = OP_STOP;
    op_data = 8'h00;
    op_nack = 1'b0;
    case (step_q)
      STEP_START: begin op = OP_START; op_data = {txn_q.dev, 1'b0}; end
      STEP_REG:   begin op = OP_WRITE; op_data = txn_q.regad; end
      STEP_SEC: begin
        if (txn_q.rw) begin op = OP_START; op_data = {txn_q.dev, 1'b1}; end
        else          begin op = OP_WRITE; op_data = txn_q.wdata; end
      end
      STEP_READ:  begin op = OP_READ; op_nack = 1'b1; end
      default:    op = OP_STOP;
    endcase
  end

`ifdef I2C_TXN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (state_q == S_ISSUE || state_q == S_WAIT) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change, including the ISSUE->ISSUE jump to STOP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                tmo_q <= '0;
    else if (state_d != state_q || tmo_hit)   tmo_q <= '0;
    else if (state_q == S_ISSUE || state_q == S_WAIT) tmo_q <= tmo_q + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    abort_d = abort_q;
    rdata_d = rdata_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: if (|bus.req_valid_i) begin adv = 1'b1; state_d = S_GRANT; end
      S_GRANT: begin step_d = STEP_START; state_d = S_ISSUE; end
      S_ISSUE: if (bus.cmd_ready_i) state_d = S_WAIT;
      S_WAIT: if (bus.done_i) begin
        if (op == OP_READ) rdata_d = bus.done_rdata_i;
        if (step_q == STEP_STOP) state_d = S_RESP;
        else begin
          state_d = S_ISSUE;
          if ((op == OP_START || op == OP_WRITE) && bus.done_ack_n_i) begin
            abort_d = 1'b1;
            step_d  = STEP_STOP;
          end else begin
            step_d = next_step(step_q, txn_q.rw);
          end
        end
      end
      S_RESP: begin abort_d = 1'b0; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
    // A watchdog expiry only matters when the primitive has made no progress.
    if (tmo_hit && state_d == state_q) begin
      abort_d = 1'b1;
      if (step_q == STEP_STOP) state_d = S_RESP;
      else begin step_d = STEP_STOP; state_d = S_ISSUE; end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      step_q  <= STEP_START;
      txn_q   <= '0;
      owner_q <= '0;
      rdata_q <= 8'h00;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
      if (adv) begin
        txn_q   <= txn_sel;
        owner_q <= gnt_idx;
      end
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE && !rst_i) ? gnt : '0;
  assign bus.cmd_valid_o = (state_q == S_ISSUE);
  assign bus.cmd_op_o    = (state_q == S_ISSUE) ? op : 2'd0;
  assign bus.cmd_data_o  = (state_q == S_ISSUE) ? op_data : 8'h00;
  assign bus.cmd_nack_o  = (state_q == S_ISSUE) && op_nack;
  assign bus.rsp_valid_o = (state_q == S_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.rsp_nack_o  = (state_q == S_RESP) && abort_q;
  assign bus.rsp_rdata_o = (state_q == S_RESP && txn_q.rw && !abort_q) ? rdata_q : 8'h00;
endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grant order, primitive lists and
// responses; an engine model and monitors pop and compare as the DUT presents them.
module tb_i2c_txn_scheduler;
  import i2c_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_txn_scheduler_if #(.NUM_REQ(N)) bus ();

  i2c_txn_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(4096)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int       k;
    bit       rw;
    bit [6:0] dev;
    bit [7:0] rg;
    bit [7:0] wd;
    int       nack_at;   // index of START/WRITE primitive the slave NACKs, -1 none
    bit [7:0] rd;
    bit       hang;      // engine never completes the READ
  } txn_s;
  typedef struct { bit [1:0] op; bit [7:0] data; bit nk; } cmd_s;
  typedef struct { int k; bit [7:0] rd; bit nk; } rsp_s;

  cmd_s exp_cmd[$];
  rsp_s exp_rsp[$];
  int   exp_gnt[$];
  txn_s script[$];
  int   model_ptr = 0;
  int   total = 0, bad = 0;
  int   active = 0;
  bit   bp_mode = 0;

  // engine model state
  bit       busy = 0, prev_wait = 0, read_hung = 0, pend_ack = 0;
  bit [1:0] pend_op = 0;
  bit [7:0] pend_rd = 0;
  bit [10:0] prev_cmd = 0;
  int       dly = 0, prim = 0, stall = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transaction-level expectation: primitive list, grant, response.
  task automatic expect_txn(txn_s t);
    cmd_s full[$];
    int   n;
    full.push_back('{2'd0, {t.dev, 1'b0}, 1'b0});
    full.push_back('{2'd1, t.rg, 1'b0});
    if (t.rw) begin
      full.push_back('{2'd0, {t.dev, 1'b1}, 1'b0});
      full.push_back('{2'd2, 8'h00, 1'b1});
    end else begin
      full.push_back('{2'd1, t.wd, 1'b0});
    end
    n = (t.nack_at >= 0) ? t.nack_at + 1 : full.size();
    for (int i = 0; i < n; i++) exp_cmd.push_back(full[i]);
    exp_cmd.push_back('{2'd3, 8'h00, 1'b0});
    exp_rsp.push_back('{t.k, (t.rw && t.nack_at < 0) ? t.rd : 8'h00, t.nack_at >= 0});
    exp_gnt.push_back(t.k);
    script.push_back(t);
  endtask

  task automatic drive(int k, txn_s ts[$]);
    int w;
    @(negedge clk);
    foreach (ts[i]) begin
      if (ts[i].k != k) continue;
      bus.req_valid_i[k]        = 1'b1;
      bus.req_rw_i[k]           = ts[i].rw;
      bus.req_dev_i[7*k +: 7]   = ts[i].dev;
      bus.req_reg_i[8*k +: 8]   = ts[i].rg;
      bus.req_wdata_i[8*k +: 8] = ts[i].wd;
      #1;
      w = 0;
      while (!bus.req_ready_o[k] && w < 3000) begin @(negedge clk); #1; w++; end
      if (w >= 3000) check("ready_timeout", 0, 1);
      @(negedge clk);
    end
    // Scramble after accept: the latched transaction must not follow.
    bus.req_valid_i[k]        = 1'b0;
    bus.req_rw_i[k]           = 1'($urandom);
    bus.req_dev_i[7*k +: 7]   = 7'($urandom);
    bus.req_reg_i[8*k +: 8]   = 8'($urandom);
    bus.req_wdata_i[8*k +: 8] = 8'($urandom);
  endtask

  task automatic run_batch(txn_s ts[$], bit wait_rsp);
    txn_s rem[$];
    int   cnt[N];
    int   w, k;
    rem = ts;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (ts[i]) cnt[ts[i].k]++;
    // Round-robin model over the held requests.
    while (rem.size() > 0) begin
      k = model_ptr;
      while (cnt[k] == 0) k = (k + 1) % N;
      foreach (rem[i]) if (rem[i].k == k) begin
        expect_txn(rem[i]);
        rem.delete(i);
        break;
      end
      cnt[k]--;
      model_ptr = (k + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      automatic int kk = i;
      active++;
      fork begin drive(kk, ts); active--; end join_none
    end
    wait (active == 0);
    if (wait_rsp) begin
      w = 0;
      while (exp_rsp.size() != 0 && w < 5000) begin @(negedge clk); w++; end
      check("rsp_drain", exp_rsp.size(), 0);
    end
  endtask

  function automatic txn_s mk(int k, bit rw, bit [6:0] dev, bit [7:0] rg, bit [7:0] wd,
                              int nack_at, bit [7:0] rd, bit hang);
    txn_s t;
    t.k = k; t.rw = rw; t.dev = dev; t.rg = rg; t.wd = wd;
    t.nack_at = nack_at; t.rd = rd; t.hang = hang;
    return t;
  endfunction

  function automatic txn_s rnd_txn(int k);
    return mk(k, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
              8'($urandom), 1'b0);
  endfunction

  // Engine model: random ready, random done latency, scripted ACK/NACK and read data.
  initial begin
    cmd_s e;
    txn_s t;
    forever begin
      @(negedge clk);
      if (rst) continue;
      bus.done_i       = 1'b0;
      bus.done_ack_n_i = 1'b0;
      bus.done_rdata_i = 8'($urandom);
      if (busy) begin
        if (dly == 0) begin
          bus.done_i       = 1'b1;
          bus.done_ack_n_i = pend_ack;
          if (pend_op == 2'd2) bus.done_rdata_i = pend_rd;
          busy = 0;
        end else dly--;
      end
      if (bus.cmd_valid_o) begin
        check("cmd_overlap", busy, 0);
        if (prev_wait) check("cmd_stable", {bus.cmd_op_o, bus.cmd_data_o, bus.cmd_nack_o}, prev_cmd);
        if (bp_mode && !prev_wait) stall = 10;
        bus.cmd_ready_i = bp_mode ? (stall == 0) : ($urandom_range(0, 3) != 0);
        if (stall > 0) stall--;
        if (bus.cmd_ready_i) begin
          prev_wait = 0;
          if (exp_cmd.size() == 0 || script.size() == 0) begin
            check("cmd_extra", {bus.cmd_op_o, bus.cmd_data_o}, 0);
          end else begin
            e = exp_cmd.pop_front();
            t = script[0];
            check("cmd", {bus.cmd_op_o, bus.cmd_data_o, bus.cmd_nack_o}, {e.op, e.data, e.nk});
            pend_op  = bus.cmd_op_o;
            pend_rd  = t.rd;
            // ACK/NACK on READ and STOP must have no effect: drive it randomly.
            pend_ack = (pend_op >= 2'd2) ? 1'($urandom) : (prim == t.nack_at);
            dly      = $urandom_range(0, 3);
            busy     = 1;
            if (pend_op == 2'd2 && t.hang) begin read_hung = 1; dly = 1000000; end
            if (pend_op == 2'd3) begin void'(script.pop_front()); prim = 0; end
            else prim++;
          end
        end else begin
          prev_wait = 1;
          prev_cmd  = {bus.cmd_op_o, bus.cmd_data_o, bus.cmd_nack_o};
        end
      end else begin
        prev_wait       = 0;
        bus.cmd_ready_i = 1'($urandom);
      end
    end
  end

  // Grant and response monitor.
  initial begin
    int   g;
    rsp_s r;
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (|bus.req_ready_o) begin
        if (exp_gnt.size() == 0) check("grant_extra", bus.req_ready_o, 0);
        else begin g = exp_gnt.pop_front(); check("grant", bus.req_ready_o, N'(1) << g); end
      end
      if (|bus.rsp_valid_o) begin
        if (exp_rsp.size() == 0) check("rsp_extra", bus.rsp_valid_o, 0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_valid", bus.rsp_valid_o, N'(1) << r.k);
          check("rsp_rdata", bus.rsp_rdata_o, r.rd);
          check("rsp_nack", bus.rsp_nack_o, r.nk);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] all_outs();
    return {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_nack_o,
            bus.cmd_valid_o, bus.cmd_op_o, bus.cmd_data_o, bus.cmd_nack_o};
  endfunction

  initial begin
    txn_s b[$];
    int   w;
    bus.req_valid_i  = '0;
    bus.req_rw_i     = '0;
    bus.req_dev_i    = '0;
    bus.req_reg_i    = '0;
    bus.req_wdata_i  = '0;
    bus.cmd_ready_i  = 1'b0;
    bus.done_i       = 1'b0;
    bus.done_ack_n_i = 1'b0;
    bus.done_rdata_i = 8'h00;
    #3;
    check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;

    // single write, single read, address NACK
    b = {}; b.push_back(mk(0, 1'b0, 7'h66, 8'h01, 8'hA5, -1, 8'h00, 1'b0)); run_batch(b, 1);
    b = {}; b.push_back(mk(1, 1'b1, 7'h1A, 8'h01, 8'h00, -1, 8'h5C, 1'b0)); run_batch(b, 1);
    b = {}; b.push_back(mk(0, 1'b1, 7'h2B, 8'h10, 8'h00,  0, 8'h77, 1'b0)); run_batch(b, 1);

    // fairness: req0 and req1 held for two transactions each
    b = {};
    for (int i = 0; i < 2; i++) begin b.push_back(rnd_txn(0)); b.push_back(rnd_txn(1)); end
    run_batch(b, 1);

    // backpressure
    bp_mode = 1;
    b = {}; b.push_back(mk(2, 1'b0, 7'h55, 8'h3C, 8'h96, -1, 8'h00, 1'b0)); run_batch(b, 1);
    bp_mode = 0;

    // reset during a stalled READ
    b = {}; b.push_back(mk(0, 1'b1, 7'h1A, 8'h02, 8'h00, -1, 8'hEE, 1'b1)); run_batch(b, 0);
    w = 0;
    while (!read_hung && w < 500) begin @(negedge clk); w++; end
    check("read_reached", read_hung, 1);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1 check("midtxn_reset_outputs", all_outs(), 0);
    exp_cmd.delete(); exp_rsp.delete(); exp_gnt.delete(); script.delete();
    busy = 0; prim = 0; read_hung = 0; prev_wait = 0; stall = 0; model_ptr = 0;
    bus.done_i = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    b = {}; b.push_back(rnd_txn(1)); b.push_back(rnd_txn(0)); run_batch(b, 1);

    // randomized batches
    for (int it = 0; it < 30; it++) begin
      b = {};
      for (int k = 0; k < N; k++) begin
        automatic int c = $urandom_range(0, 2);
        for (int j = 0; j < c; j++) b.push_back(rnd_txn(k));
      end
      if (b.size() == 0) b.push_back(rnd_txn(int'($urandom_range(0, N - 1))));
      run_batch(b, 1);
    end

    repeat (5) @(negedge clk);
    check("cmd_left", exp_cmd.size(), 0);
    check("gnt_left", exp_gnt.size(), 0);
    check("rsp_left", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
